// File: rtl/booth_digit_issuer.sv
// Radix-4 Booth digit issuer: accepts one multiplier operand and streams its
// Booth triplets, one per handshake, with decoded neg/two/zero flags.
module booth_digit_issuer #(
  parameter int DW = 8,
  parameter int IW = $clog2(DW/2+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_mult,
  input  logic          in_as,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    out_encode,
  output logic          out_as,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic          out_neg,
  output logic          out_two,
  output logic          out_zero
);

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam int SW = DW + 3;
  localparam logic [IW-1:0] LAST_S = IW'(DW/2 - 1);
  localparam logic [IW-1:0] LAST_U = IW'(DW/2);

  state_t        state_q, state_d;
  logic [SW-1:0] sr_q, sr_d;
  logic          as_q, as_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          idx_is_last;

  // Unsigned operands need one extra digit to absorb the zero-extended top bit.
  assign idx_is_last = (idx_q == (as_q ? LAST_S : LAST_U));

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      as_q  <= 1'b0;
      idx_q <= '0;
    end else begin
      sr_q  <= sr_d;
      as_q  <= as_d;
      idx_q <= idx_d;
    end
  end

  // NOTE: defaults first so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = ISSUE;
      ISSUE:   if (out_ready && idx_is_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sr_d  = sr_q;
    as_d  = as_q;
    idx_d = idx_q;
    if (state_q == IDLE && in_valid) begin
      sr_d  = {(in_as ? {2{in_mult[DW-1]}} : 2'b00), in_mult, 1'b0};
      as_d  = in_as;
      idx_d = '0;
    end else if (state_q == ISSUE && out_ready && !idx_is_last) begin
      sr_d  = {{2{sr_q[SW-1]}}, sr_q[SW-1:2]};
      idx_d = idx_q + 1'b1;
    end
  end

  always_comb begin
    in_ready   = (state_q == IDLE);
    out_valid  = 1'b0;
    out_encode = 3'b000;
    out_as     = 1'b0;
    out_idx    = '0;
    out_last   = 1'b0;
    out_neg    = 1'b0;
    out_two    = 1'b0;
    out_zero   = 1'b0;
    if (state_q == ISSUE) begin
      out_valid  = 1'b1;
      out_encode = sr_q[2:0];
      out_as     = as_q;
      out_idx    = idx_q;
      out_last   = idx_is_last;
      out_zero   = (sr_q[2:0] == 3'b000) || (sr_q[2:0] == 3'b111);
      out_two    = (sr_q[2:0] == 3'b011) || (sr_q[2:0] == 3'b100);
      out_neg    = sr_q[2] & ~out_zero;
    end
  end

endmodule

// File: tb/tb_booth_digit_issuer.sv
// Bench for booth_digit_issuer: arithmetic Booth model with per-cycle compare,
// directed literal scenarios, and randomized operands with random backpressure.
module tb_booth_digit_issuer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_mult;
  logic       in_as;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_encode;
  logic       out_as;
  logic [2:0] out_idx;
  logic       out_last;
  logic       out_neg;
  logic       out_two;
  logic       out_zero;

  int checks = 0;
  int errors = 0;
  int ops_done = 0;

  booth_digit_issuer #(.DW(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mult(in_mult), .in_as(in_as),
    .out_valid(out_valid), .out_ready(out_ready), .out_encode(out_encode),
    .out_as(out_as), .out_idx(out_idx), .out_last(out_last),
    .out_neg(out_neg), .out_two(out_two), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [2:0] enc;
    int         idx;
    bit         last;
    bit         as_;
    bit         neg;
    bit         two;
    bit         zero;
    int         value;
  } dig_t;

  dig_t q[$];
  int   acc = 0;

  // Model: digit i = -2*b[2i+1] + b[2i] + b[2i-1] of the operand's integer value.
  function automatic void push_operand(input logic [7:0] m, input bit a);
    int v, ng, b2, b1, b0, d;
    dig_t e;
    v  = a ? int'($signed(m)) : int'({24'd0, m});
    ng = a ? 4 : 5;
    for (int i = 0; i < ng; i++) begin
      b2 = (v >>> (2*i+1)) & 1;
      b1 = (v >>> (2*i)) & 1;
      b0 = (i == 0) ? 0 : ((v >>> (2*i-1)) & 1);
      d  = -2*b2 + b1 + b0;
      e.enc   = {b2[0], b1[0], b0[0]};
      e.idx   = i;
      e.last  = (i == ng-1);
      e.as_   = a;
      e.neg   = (d < 0);
      e.two   = (d == 2) || (d == -2);
      e.zero  = (d == 0);
      e.value = v;
      q.push_back(e);
    end
  endfunction

  function automatic int digit_of(input logic [2:0] enc);
    return -2*int'(enc[2]) + int'(enc[1]) + int'(enc[0]);
  endfunction

  always @(negedge clk) begin
    dig_t d;
    if (rst) begin
      q.delete();
      acc = 0;
    end else begin
      check("in_ready", int'(in_ready), int'(q.size() == 0));
      check("out_valid", int'(out_valid), int'(q.size() != 0));
      if (q.size() == 0) begin
        check("idle_outputs_zero",
              int'({out_encode, out_idx, out_last, out_as, out_neg, out_two, out_zero}), 0);
        if (in_valid) push_operand(in_mult, in_as);
      end else begin
        d = q[0];
        check("encode", int'(out_encode), int'(d.enc));
        check("idx", int'(out_idx), d.idx);
        check("last", int'(out_last), int'(d.last));
        check("as", int'(out_as), int'(d.as_));
        check("flags", int'({out_neg, out_two, out_zero}), int'({d.neg, d.two, d.zero}));
        if (out_ready) begin
          acc += digit_of(out_encode) * (1 << (2*int'(out_idx)));
          void'(q.pop_front());
          if (d.last) begin
            check("reconstruct", acc, d.value);
            ops_done++;
            acc = 0;
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] m, input logic a);
    @(posedge clk); #1;
    in_valid = 1'b1; in_mult = m; in_as = a;
    @(negedge clk);
    check("send_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_digits(input int n, input logic [4:0][2:0] e, input logic [4:0] negs);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("dir_encode", int'(out_encode), int'(e[k]));
      check("dir_idx", int'(out_idx), k);
      check("dir_last", int'(out_last), int'(k == n-1));
      check("dir_neg", int'(out_neg), int'(negs[k]));
      check("dir_busy", int'(in_ready), 0);
    end
    @(negedge clk);
    check("dir_bubble_ready", int'(in_ready), 1);
  endtask

  initial begin
    int waited;
    rst = 1'b1; in_valid = 1'b0; in_mult = 8'h00; in_as = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", int'(in_ready), 1);
    check("rst_outputs",
          int'({out_valid, out_encode, out_idx, out_last, out_as, out_neg, out_two, out_zero}), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    send(8'h5A, 1'b1);
    expect_digits(4, {3'b000, 3'b010, 3'b011, 3'b101, 3'b100}, 5'b00011);
    send(8'hFF, 1'b1);
    expect_digits(4, {3'b000, 3'b111, 3'b111, 3'b111, 3'b110}, 5'b00001);
    send(8'hFF, 1'b0);
    expect_digits(5, {3'b001, 3'b111, 3'b111, 3'b111, 3'b110}, 5'b00001);

    // Stall at idx 1 for three cycles, then resume.
    send(8'h5A, 1'b1);
    @(negedge clk);
    check("stall_idx0", int'(out_encode), 3'd4);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_hold_enc", int'(out_encode), 3'd5);
      check("stall_hold_idx", int'(out_idx), 1);
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("stall_still_idx1", int'(out_idx), 1);
    @(negedge clk);
    check("resume_enc", int'(out_encode), 3'd3);
    check("resume_idx", int'(out_idx), 2);
    @(negedge clk);
    @(negedge clk);
    check("stall_done_ready", int'(in_ready), 1);

    // Reset mid-operation with in_valid held.
    send(8'h5A, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; in_mult = 8'hFF; in_as = 1'b1;
    @(negedge clk);
    check("pre_rst_idx", int'(out_idx), 2);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", int'(in_ready), 1);
    check("post_rst_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_idx", int'(out_idx), 0);
    check("post_rst_enc", int'(out_encode), 3'd6);
    waited = 0;
    while (!in_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 1) == 1);
      in_mult   = 8'($urandom);
      in_as     = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("drain_timeout", int'(waited < 20), 1);
    check("ops_completed", int'(ops_done >= 100), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_digit_issuer.md
BOOTH_DIGIT_ISSUER -- requirements
Module: booth_digit_issuer

Interface
REQ-001 SHALL provide parameter DW, default 8, multiplier width in bits; legal values are even and >= 4.
REQ-002 SHALL provide derived parameter IW = clog2(DW/2+1), default 3, the width of the digit index.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-005 SHALL have port in_valid  input  1  operand offered.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand.
REQ-007 SHALL have port in_mult  input  DW  multiplier operand.
REQ-008 SHALL have port in_as  input  1  operand signedness; 1 = signed two's complement, 0 = unsigned.
REQ-009 SHALL have port out_valid  output  1  Booth digit presented.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the digit.
REQ-011 SHALL have port out_encode  output  3  radix-4 Booth triplet {y[2i+1], y[2i], y[2i-1]}.
REQ-012 SHALL have port out_as  output  1  latched in_as for the current operand.
REQ-013 SHALL have port out_idx  output  IW  digit index i, starting at 0.
REQ-014 SHALL have port out_last  output  1  current digit is the final digit of the operand.
REQ-015 SHALL have port out_neg / out_two / out_zero  output  1 each  decoded digit flags.

Function
REQ-016 SHALL implement a two-state FSM: IDLE and ISSUE.
REQ-017 IDLE: in_ready=1 and out_valid=0; in_valid=1 SHALL load the operand and go to ISSUE.
REQ-018 Loading SHALL latch a shift register {ext[1:0], in_mult, 1'b0} and in_as, and clear idx to 0.
REQ-019 ext SHALL be {2{in_mult[DW-1]}} when in_as=1, else 2'b00.
REQ-020 Digit count NG SHALL be DW/2 when signed and DW/2+1 when unsigned.
REQ-021 ISSUE: in_ready=0 and out_valid=1; out_encode SHALL be the low 3 bits of the shift register.
REQ-022 On out_valid & out_ready, when not last, the shift register SHALL shift right by 2 (sign-filled from ext[1]) and idx SHALL increment.
REQ-023 out_last SHALL be 1 iff idx == NG-1; a handshake while out_last=1 SHALL return the FSM to IDLE.
REQ-024 Latency: the first digit SHALL be valid in the cycle after input acceptance; with out_ready held at 1, digits SHALL issue one per cycle; total busy time is NG cycles.
REQ-025 A new operand SHALL NOT be accepted in the cycle of the last handshake; in_ready rises the following cycle (one bubble).
REQ-026 While out_valid=1 and out_ready=0, out_encode, out_idx, out_last, out_as and all flags SHALL hold stable.
REQ-027 out_zero SHALL be 1 iff out_encode is 000 or 111.
REQ-028 out_two SHALL be 1 iff out_encode is 011 or 100.
REQ-029 out_neg SHALL equal out_encode[2] & ~out_zero.
REQ-030 All flag outputs SHALL be 0 whenever out_valid=0.
REQ-031 The sum over i of digit_i * 4^i SHALL equal the operand value under its signedness.
REQ-032 in_mult and in_as SHALL be ignored when in_ready=0.

Reset
REQ-033 On rst=1 the FSM SHALL enter IDLE, with in_ready=1, out_valid=0, out_idx=0, out_last=0, out_encode=000, out_as=0 and all flags 0.
REQ-034 rst SHALL take priority over every handshake in the same cycle.
REQ-035 rst asserted mid-operation SHALL discard the operand without issuing further digits.

Verification
REQ-036 Signed 8'h5A, out_ready=1 -> encodes 100, 101, 011, 010 at idx 0-3; out_last only at idx 3.
REQ-037 Signed 8'hFF -> encodes 110, 111, 111, 111 (value -1); neg at idx 0 only.
REQ-038 Unsigned 8'hFF -> encodes 110, 111, 111, 111, 001 (5 digits, value 255); out_last at idx 4.
REQ-039 Signed 8'h5A, out_ready low for 3 cycles at idx 1 -> 101/idx 1 held stable; then resumes with 011.
REQ-040 rst at idx 2 with in_valid held -> next cycle IDLE with in_ready=1; new operand accepted afterwards starts at idx 0.
REQ-041 Random operands, both signedness values, random out_ready -> the reconstructed value equals the operand, and there is never a digit drop or duplicate.
